// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter.
package pc_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STALLED = 2'd2,
        HALTED  = 2'd3
    } pc_state_e;

endpackage : pc_pkg

// File: rtl/pc_adder.sv
// WIDTH-bit adder with carry-out. It is shared by the PC increment and the
// relative-branch target add.
module pc_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH:0] w_full;

    // Add with one extra bit so the carry-out falls out of the top bit.
    assign w_full  = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b);
    assign o_sum   = w_full[WIDTH-1:0];
    assign o_carry = w_full[WIDTH];

endmodule : pc_adder

// File: rtl/program_counter.sv
// Program counter with an IDLE/RUN/STALLED/HALTED sequencer.
// Input priority: R > HALT > BR > STALL > increment.
// Optional macro PC_REL_BRANCH_EN: the branch target is PC + BR_ADDR
// instead of the absolute BR_ADDR.
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH        = 16,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic               CLK,
    input  logic               R,
    input  logic               EN,
    input  logic               STALL,
    input  logic               BR,
    input  logic [WIDTH-1:0]   BR_ADDR,
    input  logic               HALT,
    input  logic               RESUME,
    output logic [WIDTH-1:0]   PC,
    output logic               VALID,
    output logic [STATE_W-1:0] STATE,
    output logic               WRAP
);

    pc_state_e        r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_valid;
    logic             r_wrap;

    pc_state_e        w_state_next;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_valid_next;
    logic             w_wrap_next;

    logic [WIDTH-1:0] w_add_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_target;

`ifdef PC_REL_BRANCH_EN
    // The adder is shared. A branch adds BR_ADDR and an increment adds 1.
    // Increments never happen in the same cycle as a taken branch.
    assign w_add_b  = BR ? BR_ADDR : WIDTH'(1);
    assign w_target = w_sum;
`else
    // Absolute branches. The adder only serves the increment.
    assign w_add_b  = WIDTH'(1);
    assign w_target = BR_ADDR;
`endif

    pc_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a     (r_pc),
        .i_b     (w_add_b),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (R) begin
            r_state <= IDLE;
            r_pc    <= RESET_VECTOR;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_valid <= w_valid_next;
            r_wrap  <= w_wrap_next;
        end
    end

    // Next-state selection. HALT wins over every other non-reset input.
    always_comb begin
        w_state_next = r_state;
        if (HALT) begin
            w_state_next = HALTED;
        end else begin
            case (r_state)
                IDLE:    if (EN) w_state_next = RUN;
                RUN:     if (BR) w_state_next = RUN;
                         else if (STALL) w_state_next = STALLED;
                STALLED: if (BR || !STALL) w_state_next = RUN;
                HALTED:  if (RESUME) w_state_next = RUN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Next PC, VALID and WRAP. Only an increment can raise WRAP.
    always_comb begin
        w_pc_next   = r_pc;
        w_wrap_next = 1'b0;
        if (!HALT) begin
            case (r_state)
                RUN: begin
                    if (BR) begin
                        w_pc_next = w_target;
                    end else if (!STALL && EN) begin
                        w_pc_next   = w_sum;
                        w_wrap_next = w_carry;
                    end
                end
                STALLED: if (BR) w_pc_next = w_target;
                default: w_pc_next = r_pc;
            endcase
        end
        w_valid_next = (w_state_next == RUN);
    end

    assign PC    = r_pc;
    assign VALID = r_valid;
    assign STATE = r_state;
    assign WRAP  = r_wrap;

endmodule : program_counter
